multicycle_controller: RTL and testbench



---
 rtl/multicycle_pkg.sv | 57 +++++
 rtl/multicycle_controller_alu_decoder.sv | 34 +++
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALUOp codes and datapath mux selects.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWRITE,
        S_MEMWB,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_TRAP
    } state_e;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: maps ALUOp plus funct fields to the 3-bit ALUControl.
module ALU_Decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [6:0] Op,
    output logic [2:0] ALUControl
);

    logic r_sub;

    // Only R-type with funct7[5] subtracts; addi never does.
    assign r_sub = Op[5] & funct7[5];

    always_comb begin
        ALUControl = 3'b000;
        case (ALUOp)
            ALUOP_ADD: ALUControl = 3'b000;
            ALUOP_SUB: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = r_sub ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle RISC-V datapath. Optional illegal-opcode
// trap state is built when ILLEGAL_OP_TRAP_EN is defined.
module multicycle_controller
    import multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Done,
    output logic       Trap
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;
    logic       trap_st;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWRITE: if (MemReady) state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BEQ: state_d = S_FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        Done      = 1'b0;
        trap_st   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
`ifndef ILLEGAL_OP_TRAP_EN
                // Unknown opcodes retire here as a NOP.
                Done = !(Op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
`endif
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Done     = MemReady;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                Done      = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                Done     = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_SUB;
                PCWrite = Zero;
                Done    = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP:     trap_st = 1'b1;
`endif
            default: ;
        endcase

        // Reset suppresses every write and parks the selects on their FETCH values.
        if (rst) begin
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            Done      = 1'b0;
            trap_st   = 1'b0;
            ResultSrc = RES_ALURESULT;
            ALUSrcA   = SRCA_PC;
            ALUSrcB   = SRCB_FOUR;
            alu_op    = ALUOP_ADD;
        end
    end

    assign ImmSrc = imm_src(Op);

`ifdef ILLEGAL_OP_TRAP_EN
    assign Trap = trap_st;
`else
    assign Trap = 1'b0;
`endif

    ALU_Decoder u_alu_dec (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .funct7     (funct7),
        .Op         (Op),
        .ALUControl (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full output vector against hand values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Done, Trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Done(Done), .Trap(Trap)
    );

    // {PCW,Adr,MW,IRW,RW, ResultSrc, SrcA, SrcB, ALUControl, Done, Trap}
    logic [15:0] obs;
    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ALUControl, Done, Trap};

    localparam logic [15:0] E_FETCH_RDY  = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] E_FETCH_WAIT = {5'b00000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] E_DECODE     = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] E_DECODE_NOP = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10};
    localparam logic [15:0] E_MEMADR     = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] E_MEMREAD    = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] E_MEMWB      = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [15:0] E_MEMWR_WAIT = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] E_MEMWR_RDY  = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [15:0] E_EXECR_SUB  = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b00};
    localparam logic [15:0] E_EXECI_OR   = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b011, 2'b00};
    localparam logic [15:0] E_ALUWB      = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10};
    localparam logic [15:0] E_BEQ_TAKEN  = {5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10};
    localparam logic [15:0] E_BEQ_NOT    = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10};
    localparam logic [15:0] E_JAL        = {5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] E_TRAP       = {5'b00000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01};

    // Compare at negedge+1, then advance to the next negedge for new inputs.
    task automatic step(input string tag, input logic [15:0] exp);
        #1;
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        @(negedge clk);
    endtask

    task automatic chk_imm(input string tag, input logic [6:0] op, input logic [1:0] exp);
        Op = op;
        #1;
        vectors++;
        assert (ImmSrc === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, ImmSrc, exp);
        end
    endtask

    initial begin
        rst = 1'b1; Op = 7'b0000011; funct3 = 3'b000; funct7 = 7'b0000000;
        Zero = 1'b0; MemReady = 1'b1;
        @(negedge clk);
        step("reset", E_FETCH_WAIT);
        rst = 1'b0;

        // lw, no stalls
        Op = 7'b0000011;
        step("lw_c1_fetch", E_FETCH_RDY);
        step("lw_c2_decode", E_DECODE);
        step("lw_c3_memadr", E_MEMADR);
        step("lw_c4_memread", E_MEMREAD);
        step("lw_c5_memwb", E_MEMWB);

        // sub R-type
        Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000;
        step("sub_c1_fetch", E_FETCH_RDY);
        step("sub_c2_decode", E_DECODE);
        step("sub_c3_execr", E_EXECR_SUB);
        step("sub_c4_aluwb", E_ALUWB);

        // ori I-type
        Op = 7'b0010011; funct3 = 3'b110; funct7 = 7'b0100000;
        step("ori_c1_fetch", E_FETCH_RDY);
        step("ori_c2_decode", E_DECODE);
        step("ori_c3_execi", E_EXECI_OR);
        step("ori_c4_aluwb", E_ALUWB);

        // beq taken, then not taken
        Op = 7'b1100011; funct3 = 3'b000; funct7 = 7'b0000000; Zero = 1'b1;
        step("beqT_c1_fetch", E_FETCH_RDY);
        step("beqT_c2_decode", E_DECODE);
        step("beqT_c3_beq", E_BEQ_TAKEN);
        Zero = 1'b0;
        step("beqN_c1_fetch", E_FETCH_RDY);
        step("beqN_c2_decode", E_DECODE);
        step("beqN_c3_beq", E_BEQ_NOT);

        // jal
        Op = 7'b1101111;
        step("jal_c1_fetch", E_FETCH_RDY);
        step("jal_c2_decode", E_DECODE);
        step("jal_c3_jal", E_JAL);
        step("jal_c4_aluwb", E_ALUWB);

        // fetch stall, then sw with 3 stall cycles in MEMWRITE
        Op = 7'b0100011; MemReady = 1'b0;
        step("sw_fetch_stall", E_FETCH_WAIT);
        MemReady = 1'b1;
        step("sw_c1_fetch", E_FETCH_RDY);
        MemReady = 1'b0;
        step("sw_c2_decode_mr_ignored", E_DECODE);
        MemReady = 1'b1;
        step("sw_c3_memadr_mr_ignored", E_MEMADR);
        MemReady = 1'b0;
        step("sw_memwr_stall1", E_MEMWR_WAIT);
        step("sw_memwr_stall2", E_MEMWR_WAIT);
        step("sw_memwr_stall3", E_MEMWR_WAIT);
        MemReady = 1'b1;
        step("sw_memwr_done", E_MEMWR_RDY);
        step("sw_back_to_fetch", E_FETCH_RDY);

        // lw aborted by reset in MEMREAD (continues from the fetch above)
        Op = 7'b0000011;
        step("rst_c2_decode", E_DECODE);
        step("rst_c3_memadr", E_MEMADR);
        rst = 1'b1;
        step("rst_in_memread", E_FETCH_WAIT);
        rst = 1'b0;
        step("rst_after_fetch", E_FETCH_RDY);
        step("rst_after_decode", E_DECODE);
        Op = 7'b1111111;
        step("ill_c2_sync", E_MEMADR);

        // Illegal opcode from a clean start
        rst = 1'b1;
        step("ill_reset", E_FETCH_WAIT);
        rst = 1'b0;
        step("ill_c1_fetch", E_FETCH_RDY);
`ifdef ILLEGAL_OP_TRAP_EN
        step("ill_c2_decode", E_DECODE);
        step("ill_c3_trap", E_TRAP);
        step("ill_c4_trap", E_TRAP);
        step("ill_c5_trap", E_TRAP);
        rst = 1'b1;
        step("ill_trap_reset", E_FETCH_WAIT);
        rst = 1'b0;
        step("ill_after_reset", E_FETCH_RDY);
`else
        step("ill_c2_decode_nop", E_DECODE_NOP);
        step("ill_c3_fetch", E_FETCH_RDY);
`endif

        chk_imm("imm_lw", 7'b0000011, 2'b00);
        chk_imm("imm_sw", 7'b0100011, 2'b01);
        chk_imm("imm_beq", 7'b1100011, 2'b10);
        chk_imm("imm_jal", 7'b1101111, 2'b11);
        chk_imm("imm_r", 7'b0110011, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
